// File: rtl/mmu_ram_sequencer.sv
// MMU mapping RAM port sequencer. It fills the default map after reset, then passes the CPU through,
// and runs a task-table COPY/FILL engine that uses only the registered E-low slot.
module mmu_ram_sequencer (
    input  logic       INIT_ROM_HI,
    input  logic       CLKX4,
    input  logic       nRESET,
    input  logic       QX,
    input  logic       EX,
    input  logic       MRDY,
    input  logic [7:0] cpu_addr,
    input  logic       cpu_nRD,
    input  logic       cpu_nWR,
    input  logic [7:0] cpu_dout,
    input  logic       cpu_doe,
    output logic [7:0] MMU_ADDR,
    output logic       MMU_nRD,
    output logic       MMU_nWR,
    output logic [7:0] MMU_DATA_out,
    output logic       MMU_DATA_oe,
    input  logic [7:0] MMU_DATA_in,
    output logic       nCPU_HOLD,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [4:0] cmd_src,
    input  logic [4:0] cmd_dst,
    input  logic [7:0] cmd_fill,
    output logic       done,
    output logic       busy
);

    typedef enum logic [2:0] {
        INIT_SETUP  = 3'd0,
        INIT_STROBE = 3'd1,
        INIT_HOLD   = 3'd2,
        IDLE        = 3'd3,
        CP_RD       = 3'd4,
        CP_WR       = 3'd5,
        FL_WR       = 3'd6
    } state_t;

    state_t     state_r, state_nx;
    logic [8:0] idx_r, idx_nx;
    logic [2:0] k_r, k_nx;
    logic       done_nx;
    logic       op_r;
    logic [4:0] src_r, dst_r;
    logic [7:0] fill_r, buf_r;
    logic       slot_r, done_r, nhold_r, drive_r;
    logic       in_init_s, nx_init_s, accept_s;

    // Slot s maps to page {s[0], s[2:1]} of either RAM or, for the upper half when selected, ROM0.
    function automatic logic [7:0] default_entry(input logic [2:0] s, input logic rom_hi);
        logic [1:0] dev;
        if (rom_hi && s[2]) begin
            dev = 2'b00;
        end else begin
            dev = 2'b10;
        end
        return {dev, s[0], 3'b000, s[2:1]};
    endfunction

    assign in_init_s = (state_r == INIT_SETUP) || (state_r == INIT_STROBE) || (state_r == INIT_HOLD);
    assign nx_init_s = (state_nx == INIT_SETUP) || (state_nx == INIT_STROBE) || (state_nx == INIT_HOLD);
    assign accept_s  = (state_r == IDLE) && cmd_valid;
    assign cmd_ready = (state_r == IDLE);
    assign busy      = (state_r != IDLE);
    assign done      = done_r;
    assign nCPU_HOLD = nhold_r;

    // Next-state, index and entry-counter logic.
    always_comb begin
        state_nx = state_r;
        idx_nx   = idx_r;
        k_nx     = k_r;
        done_nx  = 1'b0;
        case (state_r)
            INIT_SETUP:  state_nx = INIT_STROBE;
            INIT_STROBE: state_nx = INIT_HOLD;
            INIT_HOLD: begin
                idx_nx = idx_r + 9'd1;
                if (idx_r == 9'd255) begin
                    state_nx = IDLE;
                end else begin
                    state_nx = INIT_SETUP;
                end
            end
            IDLE: begin
                if (cmd_valid) begin
                    k_nx = 3'd0;
                    if (cmd_op) begin
                        state_nx = FL_WR;
                    end else begin
                        state_nx = CP_RD;
                    end
                end else begin
                    state_nx = IDLE;
                end
            end
            CP_RD: begin
                if (slot_r) begin
                    state_nx = CP_WR;
                end else begin
                    state_nx = CP_RD;
                end
            end
            CP_WR, FL_WR: begin
                if (slot_r) begin
                    k_nx = k_r + 3'd1;
                    if (k_r == 3'd7) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else if (state_r == CP_WR) begin
                        state_nx = CP_RD;
                    end else begin
                        state_nx = FL_WR;
                    end
                end else begin
                    state_nx = state_r;
                end
            end
            default: state_nx = INIT_SETUP;
        endcase
    end

    // State, counters, slot strobe and status registers.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            state_r <= INIT_SETUP;
            idx_r   <= 9'd0;
            k_r     <= 3'd0;
            slot_r  <= 1'b0;
            done_r  <= 1'b0;
            nhold_r <= 1'b0;
            drive_r <= 1'b0;
        end else begin
            state_r <= state_nx;
            idx_r   <= idx_nx;
            k_r     <= k_nx;
            slot_r  <= ({QX, EX} == 2'b01) && MRDY;
            done_r  <= done_nx;
            nhold_r <= !nx_init_s;
            drive_r <= 1'b1;
        end
    end

    // Command latch and copy buffer.
    always_ff @(posedge CLKX4 or negedge nRESET) begin
        if (!nRESET) begin
            op_r   <= 1'b0;
            src_r  <= 5'd0;
            dst_r  <= 5'd0;
            fill_r <= 8'd0;
            buf_r  <= 8'd0;
        end else begin
            if (accept_s) begin
                op_r   <= cmd_op;
                src_r  <= cmd_src;
                dst_r  <= cmd_dst;
                fill_r <= cmd_fill;
            end
            if ((state_r == CP_RD) && slot_r) begin
                buf_r <= MMU_DATA_in;
            end
        end
    end

    // Port mux: select depends only on registered state and slot, never on QX/EX directly.
    always_comb begin
        MMU_ADDR     = cpu_addr;
        MMU_nRD      = cpu_nRD;
        MMU_nWR      = cpu_nWR;
        MMU_DATA_out = cpu_dout;
        MMU_DATA_oe  = cpu_doe;
        if (in_init_s) begin
            MMU_ADDR     = idx_r[7:0];
            MMU_nRD      = 1'b1;
            MMU_nWR      = (state_r == INIT_STROBE) ? 1'b0 : 1'b1;
            MMU_DATA_out = default_entry(idx_r[2:0], INIT_ROM_HI);
            MMU_DATA_oe  = drive_r;
        end else if (slot_r) begin
            case (state_r)
                CP_RD: begin
                    MMU_ADDR     = {src_r, k_r};
                    MMU_nRD      = 1'b0;
                    MMU_nWR      = 1'b1;
                    MMU_DATA_out = buf_r;
                    MMU_DATA_oe  = 1'b0;
                end
                CP_WR, FL_WR: begin
                    MMU_ADDR     = {dst_r, k_r};
                    MMU_nRD      = 1'b1;
                    MMU_nWR      = 1'b0;
                    MMU_DATA_out = (state_r == FL_WR) ? fill_r : buf_r;
                    MMU_DATA_oe  = 1'b1;
                end
                default: MMU_ADDR = cpu_addr;
            endcase
        end else begin
            MMU_ADDR = cpu_addr;
        end
    end

endmodule

// File: tb/tb_mmu_ram_sequencer.sv
// Directed bench for mmu_ram_sequencer: behavioural RAM, quarter-phase E/Q generator with MRDY stretch,
// table-driven CPU pass-through vectors and hand-written COPY/FILL/reset sequences.
module tb_mmu_ram_sequencer;

    logic CLKX4 = 1'b0;
    always #5 CLKX4 = ~CLKX4;

    logic       INIT_ROM_HI = 1'b1;
    logic       nRESET, MRDY, QX, EX;
    logic [1:0] ph;
    logic [7:0] cpu_addr, cpu_dout;
    logic       cpu_nRD, cpu_nWR, cpu_doe;
    logic [7:0] MMU_ADDR, MMU_DATA_out, MMU_DATA_in;
    logic       MMU_nRD, MMU_nWR, MMU_DATA_oe;
    logic       nCPU_HOLD, cmd_valid, cmd_ready, cmd_op, done, busy;
    logic [4:0] cmd_src, cmd_dst;
    logic [7:0] cmd_fill;

    assign QX = ph[1];
    assign EX = ph[0];

    mmu_ram_sequencer dut (
        .INIT_ROM_HI(INIT_ROM_HI), .CLKX4(CLKX4), .nRESET(nRESET), .QX(QX), .EX(EX), .MRDY(MRDY),
        .cpu_addr(cpu_addr), .cpu_nRD(cpu_nRD), .cpu_nWR(cpu_nWR), .cpu_dout(cpu_dout), .cpu_doe(cpu_doe),
        .MMU_ADDR(MMU_ADDR), .MMU_nRD(MMU_nRD), .MMU_nWR(MMU_nWR), .MMU_DATA_out(MMU_DATA_out),
        .MMU_DATA_oe(MMU_DATA_oe), .MMU_DATA_in(MMU_DATA_in), .nCPU_HOLD(nCPU_HOLD),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_src(cmd_src),
        .cmd_dst(cmd_dst), .cmd_fill(cmd_fill), .done(done), .busy(busy)
    );

    // Behavioural mapping RAM: asynchronous read, write sampled at the clock edge.
    logic [7:0] mem [0:255];
    logic       wipe;
    assign MMU_DATA_in = mem[MMU_ADDR];
    always @(posedge CLKX4) begin
        if (wipe) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'hEE;
        end else if (!MMU_nWR) begin
            mem[MMU_ADDR] <= MMU_DATA_out;
        end
    end

    int checks = 0, failures = 0;
    int cyc, acc_cnt, done_cnt, pt_cnt, pt_err, rdy_err, stall_acc, n, mism, wr;
    bit rand_cpu;

    typedef struct {
        logic [7:0] addr;
        logic       nrd;
        logic       nwr;
        logic [7:0] wd;
        logic       doe;
        logic       chk_rd;
        logic [7:0] rd;
    } vec_t;
    vec_t tbl [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Default map entry with ROM0 selected for the upper slots.
    function automatic logic [7:0] dflt(input logic [7:0] a);
        logic [1:0] dev;
        dev = a[2] ? 2'b00 : 2'b10;
        return {dev, a[0], 3'b000, a[2:1]};
    endfunction

    task automatic tick();
        @(posedge CLKX4);
        #1;
        case (ph)
            2'b00:   ph = 2'b10;
            2'b10:   ph = 2'b11;
            2'b11:   ph = 2'b01;
            default: if (MRDY) ph = 2'b00;
        endcase
        if (rand_cpu) cpu_addr = 8'($urandom_range(0, 255));
        #1;
        cyc++;
        if (done) done_cnt++;
        if (nCPU_HOLD && cpu_nRD && cpu_nWR && (!MMU_nRD || !MMU_nWR)) begin
            acc_cnt++;
            if (!MRDY) stall_acc++;
        end
        if (busy && nCPU_HOLD && MMU_nRD && MMU_nWR) begin
            pt_cnt++;
            if (MMU_ADDR !== cpu_addr) pt_err++;
        end
        if ((busy && cmd_ready) || (!nCPU_HOLD && (cmd_ready || !busy))) rdy_err++;
    endtask

    task automatic issue(input logic op, input logic [4:0] s, input logic [4:0] d,
                         input logic [7:0] f, input bit keep);
        int k;
        cmd_op = op; cmd_src = s; cmd_dst = d; cmd_fill = f; cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 2000) begin tick(); k++; end
        chk("hs_ready", cmd_ready, 1'b1);
        cyc = 0; acc_cnt = 0; done_cnt = 0;
        tick();
        chk("hs_busy", busy, 1'b1);
        if (!keep) cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int limit);
        while (!done && cyc < limit) tick();
        chk(nm, done, 1'b1);
    endtask

    task automatic wait_init(input string nm);
        n = 0;
        while (!nCPU_HOLD && n < 2000) begin tick(); n++; end
        chk(nm, n, 768);
    endtask

    task automatic sweep(input string nm);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== dflt(8'(i))) mism++;
        chk(nm, mism, 0);
    endtask

    initial begin
        for (int i = 0; i < 6; i++) tbl[i].chk_rd = 1'b1;
        tbl[0] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h80};
        tbl[1] = '{8'h05, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h22};
        tbl[2] = '{8'hFF, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h23};
        tbl[3] = '{8'h1A, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h81};
        tbl[4] = '{8'h0C, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h02};
        tbl[5] = '{8'h0B, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'hA1};
        for (int i = 0; i < 8; i++) tbl[6 + i] = '{8'(i), 1'b1, 1'b0, 8'(8'h10 + i), 1'b1, 1'b0, 8'h00};
        tbl[14] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h10};
        tbl[15] = '{8'h07, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 8'h17};

        ph = 2'b00; MRDY = 1'b1; nRESET = 1'b0; wipe = 1'b1; rand_cpu = 1'b0;
        cpu_addr = 8'h00; cpu_nRD = 1'b1; cpu_nWR = 1'b1; cpu_dout = 8'h00; cpu_doe = 1'b0;
        cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = 5'd0; cmd_dst = 5'd0; cmd_fill = 8'h00;
        cyc = 0; acc_cnt = 0; done_cnt = 0; pt_cnt = 0; pt_err = 0; rdy_err = 0; stall_acc = 0;
        tick(); tick();

        chk("rst_nhold", nCPU_HOLD, 1'b0);
        chk("rst_busy", busy, 1'b1);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_nrd", MMU_nRD, 1'b1);
        chk("rst_nwr", MMU_nWR, 1'b1);
        chk("rst_oe", MMU_DATA_oe, 1'b0);
        chk("rst_addr", MMU_ADDR, 8'h00);

        wipe = 1'b0; nRESET = 1'b1;
        wait_init("init_len");
        sweep("init_sweep");

        // Pass-through reads of the default map and CPU writes of task 0.
        for (int i = 0; i < 16; i++) begin
            cpu_addr = tbl[i].addr; cpu_nRD = tbl[i].nrd; cpu_nWR = tbl[i].nwr;
            cpu_dout = tbl[i].wd; cpu_doe = tbl[i].doe;
            #1;
            chk("pt_addr", MMU_ADDR, tbl[i].addr);
            chk("pt_nrd", MMU_nRD, tbl[i].nrd);
            chk("pt_nwr", MMU_nWR, tbl[i].nwr);
            chk("pt_oe", MMU_DATA_oe, tbl[i].doe);
            chk("pt_dout", MMU_DATA_out, tbl[i].wd);
            if (tbl[i].chk_rd) chk("pt_rdata", MMU_DATA_in, tbl[i].rd);
            tick();
        end
        cpu_nRD = 1'b1; cpu_nWR = 1'b1; cpu_doe = 1'b0; cpu_dout = 8'h00;

        issue(1'b1, 5'd0, 5'd3, 8'h5A, 1'b0);
        wait_done("fill_done", 200);
        chk("fill_latency", (cyc >= 30 && cyc <= 33), 1'b1);
        tick();
        chk("fill_pulse", done, 1'b0);
        chk("fill_done_cnt", done_cnt, 1);
        chk("fill_slots", acc_cnt, 8);
        mism = 0;
        for (int i = 8'h18; i <= 8'h1F; i++) if (mem[i] !== 8'h5A) mism++;
        chk("fill_data", mism, 0);
        chk("fill_below", mem[8'h17], 8'h23);
        chk("fill_above", mem[8'h20], 8'h80);

        rand_cpu = 1'b1; pt_cnt = 0; pt_err = 0;
        issue(1'b0, 5'd0, 5'd31, 8'h00, 1'b0);
        wait_done("copy_done", 300);
        chk("copy_latency", (cyc >= 62 && cyc <= 65), 1'b1);
        chk("copy_slots", acc_cnt, 16);
        chk("copy_pt_err", pt_err, 0);
        chk("copy_pt_seen", (pt_cnt > 40), 1'b1);
        rand_cpu = 1'b0;
        tick();
        mism = 0;
        for (int i = 0; i < 8; i++) if (mem[8'hF8 + i] !== 8'(8'h10 + i)) mism++;
        chk("copy_data", mism, 0);

        issue(1'b0, 5'd31, 5'd1, 8'h00, 1'b0);
        n = 0;
        while (acc_cnt < 8 && n < 200) begin tick(); n++; end
        n = 0;
        while (ph != 2'b11 && n < 8) begin tick(); n++; end
        MRDY = 1'b0; stall_acc = 0;
        repeat (10) tick();
        chk("stall_phase", ph, 2'b01);
        MRDY = 1'b1;
        chk("stall_no_access", stall_acc, 0);
        wait_done("stall_done", 400);
        chk("stall_slots", acc_cnt, 16);
        tick();
        mism = 0;
        for (int i = 0; i < 8; i++) if (mem[8'h08 + i] !== 8'(8'h10 + i)) mism++;
        chk("stall_data", mism, 0);

        // Second command held valid throughout the first one.
        issue(1'b0, 5'd1, 5'd2, 8'h00, 1'b1);
        cmd_op = 1'b1; cmd_dst = 5'd4; cmd_fill = 8'h3C;
        wait_done("b2b_done1", 300);
        chk("b2b_ready", cmd_ready, 1'b1);
        cyc = 0; acc_cnt = 0; done_cnt = 0;
        tick();
        chk("b2b_start", busy, 1'b1);
        chk("b2b_pulse", done, 1'b0);
        cmd_valid = 1'b0;
        wait_done("b2b_done2", 200);
        chk("b2b_slots", acc_cnt, 8);
        tick();
        mism = 0;
        for (int i = 0; i < 8; i++) begin
            if (mem[8'h10 + i] !== 8'(8'h10 + i)) mism++;
            if (mem[8'h20 + i] !== 8'h3C) mism++;
        end
        chk("b2b_data", mism, 0);

        // Reset during the 4th write of a COPY, with a FILL held valid through INIT.
        issue(1'b0, 5'd3, 5'd0, 8'h00, 1'b1);
        cmd_op = 1'b1; cmd_dst = 5'd5; cmd_fill = 8'hA5;
        wr = 0; n = 0;
        while (wr < 4 && n < 300) begin
            tick(); n++;
            if (!MMU_nWR && nCPU_HOLD) wr++;
        end
        chk("rst_mid_write", wr, 4);
        done_cnt = 0;
        nRESET = 1'b0;
        #2;
        chk("rst_mid_nhold", nCPU_HOLD, 1'b0);
        chk("rst_mid_nwr", MMU_nWR, 1'b1);
        nRESET = 1'b1;
        wait_init("reinit_len");
        chk("rst_no_done", done_cnt, 0);
        sweep("reinit_sweep");
        chk("reinit_ready", cmd_ready, 1'b1);
        cyc = 0; acc_cnt = 0; done_cnt = 0;
        tick();
        chk("reinit_accept", busy, 1'b1);
        cmd_valid = 1'b0;
        wait_done("reinit_fill_done", 200);
        tick();
        mism = 0;
        for (int i = 0; i < 8; i++) if (mem[8'h28 + i] !== 8'hA5) mism++;
        chk("reinit_fill_data", mism, 0);

        chk("ready_while_busy", rdy_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mmu_ram_sequencer.md
# mmu_ram_sequencer

Owns the shared port of the MMU mapping RAM. After reset it holds the CPU off and fills all 256 entries with a default map. It then arbitrates between the CPU-side MMU logic, which translates every cycle and accesses registers at FE30-FE3F, and a background task-table engine that copies or fills the 8 entries of one task. The engine uses only the idle E-low slot of each bus cycle.

## Interface
- INIT_ROM_HI, 1: when 1, default entries for slots 4-7 select device 2'b00 (ROM0); when 0, all default entries select 2'b10 (RAM).
- CLKX4  in  1  clock, 4x E; same clock that generates QX/EX.
- nRESET  in  1  reset, asynchronous, active-low.
- QX, EX, MRDY  in  1 each  clock-generator state and ready.
- cpu_addr  in  8  MMU RAM address from the CPU-side MMU.
- cpu_nRD, cpu_nWR  in  1 each  CPU-side RAM read/write strobes.
- cpu_dout  in  8  CPU-side RAM write data.
- cpu_doe  in  1  CPU-side RAM write-data enable.
- MMU_ADDR  out  8  RAM address.
- MMU_nRD, MMU_nWR  out  1 each  RAM strobes.
- MMU_DATA_out  out  8  RAM write data.
- MMU_DATA_oe  out  1  RAM write-data enable.
- MMU_DATA_in  in  8  RAM read data.
- nCPU_HOLD  out  1  low holds the CPU in reset; asserted during init.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when valid & ready at a CLKX4 edge.
- cmd_op  in  1  0 = COPY, 1 = FILL.
- cmd_src, cmd_dst  in  5 each  source and destination task keys.
- cmd_fill  in  8  FILL data value.
- done  out  1  one-CLKX4 pulse when a command completes.
- busy  out  1  high when not in IDLE.

## Operation
- Address format: {task[4:0], slot[2:0]}.
- Default entry for slot s: {dev, s[0], 3'b000, s[2:1]}. dev = 2'b00 if INIT_ROM_HI & s[2], otherwise 2'b10.
- States:
  - INIT_SETUP, INIT_STROBE, INIT_HOLD: a loop over a 9-bit counter idx covering 0..255.
  - IDLE.
  - CP_RD, CP_WR: COPY.
  - FL_WR: FILL.
- INIT:
  - Sequencer owns the port continuously and nCPU_HOLD = 0.
  - SETUP registers address and data, with MMU_DATA_oe = 1.
  - STROBE drives MMU_nWR = 0.
  - HOLD releases nWR and increments idx.
  - After idx 255 HOLD, go to IDLE; nCPU_HOLD rises on the same edge.
- IDLE:
  - cmd_ready = 1.
  - On handshake, latch op/src/dst/fill, clear entry counter k (3 bits), and go to CP_RD (op 0) or FL_WR (op 1).
- Slot: `slot` is a register set at a CLKX4 edge where {QX,EX}==2'b01 and MRDY=1, and clear otherwise. It is high for exactly one CLKX4 cycle per E cycle, during state 00.
- While slot=0 outside INIT, all MMU_* outputs pass the cpu_* inputs through unchanged.
- Each engine state acts only when slot=1. In that cycle the sequencer owns the port:
  - CP_RD: MMU_ADDR = {src,k}, MMU_nRD = 0. MMU_DATA_in is captured into buf at the end of the cycle. Next state CP_WR.
  - CP_WR: MMU_ADDR = {dst,k}, MMU_DATA_out = buf, MMU_DATA_oe = 1, MMU_nWR = 0. k increments.
  - FL_WR: same write cycle as CP_WR, using cmd_fill instead of buf. k increments.
- Completion: a write with k == 7 pulses done and returns to IDLE. Otherwise COPY goes back to CP_RD and FILL stays in FL_WR.
- src == dst is legal; entries are rewritten with their own values.
- cmd_valid during INIT or a command is ignored; cmd_ready = 0.

## Timing
- Reset values:
  - State INIT_SETUP, idx = 0, nCPU_HOLD = 0, busy = 1.
  - cmd_ready = 0, done = 0.
  - MMU_nRD = 1, MMU_nWR = 1, MMU_DATA_oe = 0, MMU_ADDR = 0.
- Init length: exactly 768 CLKX4 cycles from reset release to nCPU_HOLD = 1.
- Engine latency:
  - COPY: 16 slots (16 E cycles).
  - FILL: 8 slots.
  - done follows the edge that ends the final write.
- Port ownership switches only at CLKX4 edges via registered `slot`, so mux select has no combinational dependency on QX/EX.
- MRDY low: state 01 persists, no slot is generated, and the engine stalls with all state preserved.
- Reset asserted mid-command: the command is abandoned, INIT restarts and rewrites the whole RAM, and no done pulse occurs.
- A handshake and the final-write edge cannot coincide, because cmd_ready is 0 outside IDLE.

## Test plan
- Reset then release, sweep readback → entry 0x00 = 0x80, 0x05 = 0x22 (INIT_ROM_HI=1), 0xFF = 0x23. nCPU_HOLD rises at cycle 768.
- FILL dst=3 data=0x5A → entries 0x18-0x1F = 0x5A, 0x20 unchanged. done pulses once, 8 E cycles after the handshake.
- COPY src=0 dst=31 → entries 0xF8-0xFF equal 0x00-0x07. Between slots, MMU_ADDR equals cpu_addr every cycle.
- COPY with MRDY held low for 10 CLKX4 cycles midway → no RAM access during the stall, final contents correct, 16 slots total.
- cmd_valid held high during INIT and during a COPY → no acceptance until IDLE. The second command starts the cycle after done.
- nRESET pulsed during the 4th COPY write → nCPU_HOLD = 0, entire RAM restored to the default map, no done pulse.
